// File: rtl/rv32im_dmem_pkg.sv
// Shared constants and FSM state type for the rv32im data-memory responder.
package rv32im_dmem_pkg;

  localparam int unsigned API_ADDR_WIDTH = 32;
  localparam int unsigned API_DATA_WIDTH = 32;
  localparam int unsigned API_STRB_WIDTH = 4;

  localparam int unsigned             DMEM_DEFAULT_DEPTH = 1024;
  localparam logic [API_ADDR_WIDTH-1:0] DMEM_DEFAULT_BASE  = 32'h0000_2000;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE = 2'd0,
    DMEM_ST_WAIT = 2'd1,
    DMEM_ST_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/rv32im_dmem_sram.sv
// Synchronous single-port word array with per-byte write lanes and a registered read port.
module rv32im_dmem_sram
  import rv32im_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DMEM_DEFAULT_DEPTH,
  parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic                      clk_i,
  input  logic                      en_i,
  input  logic                      we_i,
  input  logic [API_STRB_WIDTH-1:0] strb_i,
  input  logic [IDX_W-1:0]          idx_i,
  input  logic [API_DATA_WIDTH-1:0] wdata_i,
  output logic [API_DATA_WIDTH-1:0] rdata_o
);

  logic [API_DATA_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [API_DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int unsigned i = 0; i < API_STRB_WIDTH; i++) begin
          if (strb_i[i]) mem[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rv32im_dmem.sv
// Single-outstanding data-memory responder with configurable latency.
// Optional bounds checking is compiled in with `DMEM_BOUNDS_CHECK_EN.
module rv32im_dmem
  import rv32im_dmem_pkg::*;
#(
  parameter int unsigned                DEPTH_WORDS = DMEM_DEFAULT_DEPTH,
  parameter int unsigned                LATENCY     = 1,
  parameter logic [API_ADDR_WIDTH-1:0]  BASE_ADDR   = DMEM_DEFAULT_BASE
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [API_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [API_DATA_WIDTH-1:0] req_wdata_i,
  input  logic [API_STRB_WIDTH-1:0] req_wstrb_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [API_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [API_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [API_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [API_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                      ready_q, ready_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic                      rsp_err_q, rsp_err_d;
  logic                      rd_ok_q, rd_ok_d;

  logic                      commit;
  logic                      addr_err;
  logic [API_ADDR_WIDTH-1:0] offset;
  logic [API_DATA_WIDTH-1:0] sram_rdata;
  logic                      unused_bits;

  assign offset      = addr_q - BASE_ADDR;
  assign unused_bits = ^offset;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign addr_err = ({2'b00, offset[API_ADDR_WIDTH-1:2]} >= API_ADDR_WIDTH'(DEPTH_WORDS));
`else
  assign addr_err = 1'b0;
`endif

  // Counter holds remaining wait cycles; zero means commit on the next edge,
  // which gives accept-to-valid of exactly LATENCY edges.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    ready_d     = ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rd_ok_d     = rd_ok_q;
    commit      = 1'b0;
    unique case (state_q)
      DMEM_ST_IDLE: begin
        ready_d = 1'b1;
        if (req_valid_i && ready_q) begin
          we_d    = req_we_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          wstrb_d = req_wstrb_i;
          cnt_d   = CNT_W'(LATENCY - 1);
          ready_d = 1'b0;
          state_d = DMEM_ST_WAIT;
        end
      end
      DMEM_ST_WAIT: begin
        if (cnt_q == '0) begin
          commit      = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = addr_err;
          rd_ok_d     = !we_q && !addr_err;
          state_d     = DMEM_ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DMEM_ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rd_ok_d     = 1'b0;
          ready_d     = 1'b1;
          state_d     = DMEM_ST_IDLE;
        end
      end
      default: state_d = DMEM_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= DMEM_ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rd_ok_q     <= rd_ok_d;
    end
  end

  // The array lives outside the reset domain, so the commit is gated by reset here.
  rv32im_dmem_sram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (commit && rst_n_i && !addr_err),
    .we_i    (we_q),
    .strb_i  (wstrb_q),
    .idx_i   (offset[IDX_W+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rd_ok_q ? sram_rdata : '0;

endmodule
